// File: rtl/video_pattern_gen.sv
// video_pattern_gen: VGA-style raster timing with colorbar, gray ramp, checkerboard and white patterns.
// Define PATTERN_BORDER_EN to draw a one-pixel white border around the active area.
module video_pattern_gen #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_VALID = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_VALID = 480,
    parameter int V_FRONT = 10,
    parameter int COLOR_W = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         mode,
    output logic               hsync,
    output logic               vsync,
    output logic               rgb_valid,
    output logic [11:0]        pix_x,
    output logic [11:0]        pix_y,
    output logic [COLOR_W-1:0] rgb_r,
    output logic [COLOR_W-1:0] rgb_g,
    output logic [COLOR_W-1:0] rgb_b,
    output logic               frame_start
);
    localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_VALID + H_FRONT);
    localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_VALID + V_FRONT);
    localparam logic [11:0] H_ACT   = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_END   = 12'(H_SYNC + H_BACK + H_VALID);
    localparam logic [11:0] V_ACT   = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_END   = 12'(V_SYNC + V_BACK + V_VALID);
    localparam logic [11:0] BAR_W   = 12'(H_VALID / 8);
    localparam logic [COLOR_W-1:0] FULL = '1;

    logic [11:0]        cnt_h, cnt_v, px, py;
    logic [1:0]         mode_reg;
    logic               h_last, v_last, act;
    logic [2:0]         bar;
    logic [COLOR_W-1:0] gray, r, g, b;

    always_comb begin
        h_last = cnt_h == H_TOTAL - 12'd1;
        v_last = cnt_v == V_TOTAL - 12'd1;
        act    = cnt_h >= H_ACT && cnt_h < H_END && cnt_v >= V_ACT && cnt_v < V_END;
        px     = act ? cnt_h - H_ACT : '0;
        py     = act ? cnt_v - V_ACT : '0;
        bar    = 3'(px / BAR_W);
        gray   = COLOR_W'(px);
        // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
        r = mode_reg == 2'd0 ? {COLOR_W{~bar[1]}} : mode_reg == 2'd1 ? gray :
            mode_reg == 2'd2 ? {COLOR_W{px[5] ^ py[5]}} : FULL;
        g = mode_reg == 2'd0 ? {COLOR_W{~bar[2]}} : mode_reg == 2'd1 ? gray :
            mode_reg == 2'd2 ? {COLOR_W{px[5] ^ py[5]}} : FULL;
        b = mode_reg == 2'd0 ? {COLOR_W{~bar[0]}} : mode_reg == 2'd1 ? gray :
            mode_reg == 2'd2 ? {COLOR_W{px[5] ^ py[5]}} : FULL;
`ifdef PATTERN_BORDER_EN
        if (px == 12'd0 || px == 12'(H_VALID - 1) || py == 12'd0 || py == 12'(V_VALID - 1)) begin
            r = FULL;
            g = FULL;
            b = FULL;
        end
`endif
        if (!act) begin
            r = '0;
            g = '0;
            b = '0;
        end
    end

    // Pattern changes only at the frame boundary so a frame is never mixed.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h    <= '0;
            cnt_v    <= '0;
            mode_reg <= '0;
        end else begin
            cnt_h <= h_last ? '0 : cnt_h + 12'd1;
            if (h_last) cnt_v <= v_last ? '0 : cnt_v + 12'd1;
            if (h_last && v_last) mode_reg <= mode;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            rgb_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= cnt_h < 12'(H_SYNC);
            vsync       <= cnt_v < 12'(V_SYNC);
            rgb_valid   <= act;
            pix_x       <= px;
            pix_y       <= py;
            rgb_r       <= r;
            rgb_g       <= g;
            rgb_b       <= b;
            frame_start <= cnt_h == 12'd0 && cnt_v == 12'd0;
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: randomized-mode raster check against a frame-level reference model.
// Shrunk timing keeps several full frames within the cycle budget.
module tb_video_pattern_gen;
    localparam int HS = 8, HB = 8, HV = 128, HF = 8;
    localparam int VS = 2, VB = 3, VV = 40, VF = 2;
    localparam int CW = 6;
    localparam int HT = HS + HB + HV + HF;
    localparam int VT = VS + VB + VV + VF;
    localparam int FRAME = HT * VT;
    localparam int OW = 28 + 3 * CW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic          hsync, vsync, rgb_valid, frame_start;
    logic [11:0]   pix_x, pix_y;
    logic [CW-1:0] rgb_r, rgb_g, rgb_b;
    logic [OW-1:0] obs, exp_v;

    int checks = 0;
    int failures = 0;
    int t = 0;
    int fmode = 0;

    video_pattern_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF), .COLOR_W(CW)
    ) dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .mode(mode),
        .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid),
        .pix_x(pix_x), .pix_y(pix_y),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    assign obs = {frame_start, hsync, vsync, rgb_valid, pix_x, pix_y, rgb_r, rgb_g, rgb_b};

    // Bar colours as {r,g,b} presence, left to right.
    localparam bit [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

    function automatic logic [OW-1:0] model(input int tt, input int fm);
        int h, v, px, py;
        bit act;
        bit [2:0] c;
        logic [CW-1:0] full, r, g, b;
        h = tt % HT;
        v = (tt / HT) % VT;
        act = h >= HS + HB && h < HS + HB + HV && v >= VS + VB && v < VS + VB + VV;
        px = act ? h - HS - HB : 0;
        py = act ? v - VS - VB : 0;
        full = '1;
        c = 3'b111;
        if (fm == 0) c = BARS[px / (HV / 8)];
        else if (fm == 2) c = (((px / 32) + (py / 32)) % 2 == 1) ? 3'b111 : 3'b000;
        r = c[2] ? full : '0;
        g = c[1] ? full : '0;
        b = c[0] ? full : '0;
        if (fm == 1) begin
            r = CW'(px % (1 << CW));
            g = r;
            b = r;
        end
`ifdef PATTERN_BORDER_EN
        if (px == 0 || px == HV - 1 || py == 0 || py == VV - 1) begin
            r = full;
            g = full;
            b = full;
        end
`endif
        if (!act) begin
            r = '0;
            g = '0;
            b = '0;
        end
        return {h == 0 && v == 0, h < HS, v < VS, act, 12'(px), 12'(py), r, g, b};
    endfunction

    // Advance one clock; exp_v holds what the outputs must show for counter time t.
    task automatic tick();
        @(posedge clk);
        #1;
        exp_v = model(t, fmode);
        if (t % FRAME == FRAME - 1) fmode = int'(mode);
        t++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        fmode = 0;
    endtask

    task automatic test_reset();
        mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL reset_hold got=%h exp=0", obs);
            end
        end
        mode = 2'd0;
        release_reset();
    endtask

    task automatic test_colorbar_timing();
        int starts[$];
        int hs_cnt;
        hs_cnt = 0;
        for (int i = 0; i < FRAME + 10; i++) begin
            tick();
            if (frame_start) starts.push_back(t);
            if (hsync && t <= HT) hs_cnt++;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL colorbar t=%0d got=%h exp=%h", t - 1, obs, exp_v);
            end
        end
        checks++;
        if (starts.size() != 2 || starts[1] - starts[0] != FRAME) begin
            failures++;
            $display("FAIL frame_period pulses=%0d exp=2 period=%0d",
                     starts.size(), starts.size() == 2 ? starts[1] - starts[0] : -1);
        end
        checks++;
        if (hs_cnt != HS) begin
            failures++;
            $display("FAIL hsync_width got=%0d exp=%0d", hs_cnt, HS);
        end
    endtask

    task automatic test_mode_switch();
        int order [4] = '{1, 2, 3, 0};
        for (int f = 0; f < 4; f++) begin
            int sw;
            sw = $urandom_range(100, FRAME - 200);
            while (t % FRAME != 0) tick();
            for (int i = 0; i < FRAME; i++) begin
                tick();
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL mode_switch f=%0d t=%0d got=%h exp=%h", f, t - 1, obs, exp_v);
                end
                if (i == sw / 2 || $urandom_range(0, 999) == 0) mode = 2'($urandom_range(0, 3));
                if (i == sw) mode = 2'(order[f]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int first_act;
        while ((t % FRAME) / HT != 20) tick();
        mode = 2'd3;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL async_clear got=%h exp=0", obs);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL midframe_hold got=%h exp=0", obs);
            end
        end
        release_reset();
        first_act = -1;
        for (int i = 1; i <= FRAME + 20; i++) begin
            tick();
            if (rgb_valid && first_act < 0) first_act = i;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL after_reset clk=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        checks++;
        if (first_act != (VS + VB) * HT + HS + HB + 1) begin
            failures++;
            $display("FAIL first_active got=%0d exp=%0d", first_act, (VS + VB) * HT + HS + HB + 1);
        end
    endtask

    initial begin
        test_reset();
        test_colorbar_timing();
        test_mode_switch();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
